// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
//   Decodes the host byte stream from the UART receiver, assembles 32-bit
//   little-endian instruction words into instruction-memory writes, and
//   gates CPU execution (single-step / run / halt).
//
//   Optional feature macro: UART_CMD_ACK_EN
//     defined   : every completed command is acknowledged with opcode|0x80
//                 on tx_data/tx_valid, held until tx_ready.
//     undefined : tx_valid/tx_data tied 0, tx_ready ignored, no ACK state.
//
//   Ports
//     clk, reset          system clock, synchronous active-high reset
//     rx_data, rx_valid   received byte and its 1-cycle strobe
//     imem_we/addr/wdata  instruction-memory write port (1-cycle strobe)
//     cpu_en              CPU clock enable (run flag | step pulse)
//     busy                high whenever the FSM is not idle
//     cmd_err             1-cycle pulse: unknown opcode, LOAD timeout, overrun
//     tx_data, tx_valid   acknowledge byte (UART_CMD_ACK_EN only)
//     tx_ready            UART TX accepts the acknowledge byte
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for an opcode byte
//   ST_LOAD  | collecting 4 data bytes, idle-timeout counter running
//   ST_WRITE | one-cycle imem write of the assembled word
//   ST_ACK   | acknowledge byte presented until tx_ready (ACK build only)
module uart_cmd_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT_CYC = 2_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_en,
   output logic              busy,
   output logic              cmd_err,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_ACK   = 2'd3;

`ifdef UART_CMD_ACK_EN
   localparam logic [1:0] ST_DONE  = ST_ACK;
`else
   localparam logic [1:0] ST_DONE  = ST_IDLE;
`endif

   localparam logic [7:0] OP_LOAD = 8'h00;
   localparam logic [7:0] OP_CLR  = 8'h01;
   localparam logic [7:0] OP_STEP = 8'h02;
   localparam logic [7:0] OP_RUN  = 8'h03;
   localparam logic [7:0] OP_HALT = 8'h04;

   // Down-counter reloaded with TIMEOUT_CYC-1; terminal count at zero means
   // TIMEOUT_CYC consecutive cycles passed without a byte.
   localparam int              CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TIMEOUT_CYC - 1);

   logic [1:0]        state;
   logic [1:0]        bc;
   logic [31:0]       word;
   logic [ADDR_W-1:0] wp;
   logic              run_flag;
   logic              step_pulse;
   logic [CNT_W-1:0]  idle_cnt;
`ifdef UART_CMD_ACK_EN
   logic [7:0]        opcode;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         bc         <= 2'd0;
         word       <= 32'h0;
         wp         <= '0;
         run_flag   <= 1'b0;
         step_pulse <= 1'b0;
         cmd_err    <= 1'b0;
         idle_cnt   <= CNT_INIT;
`ifdef UART_CMD_ACK_EN
         opcode     <= 8'h00;
`endif
      end else begin
         step_pulse <= 1'b0;
         cmd_err    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_valid) begin
`ifdef UART_CMD_ACK_EN
                  opcode <= rx_data;
`endif
                  case (rx_data)
                     OP_LOAD: begin
                        state    <= ST_LOAD;
                        bc       <= 2'd0;
                        word     <= 32'h0;
                        run_flag <= 1'b0;
                        idle_cnt <= CNT_INIT;
                     end
                     OP_CLR: begin
                        wp    <= '0;
                        state <= ST_DONE;
                     end
                     OP_STEP: begin
                        // a step while running is swallowed; the run flag
                        // already holds cpu_en high
                        step_pulse <= ~run_flag;
                        state      <= ST_DONE;
                     end
                     OP_RUN: begin
                        run_flag <= 1'b1;
                        state    <= ST_DONE;
                     end
                     OP_HALT: begin
                        run_flag <= 1'b0;
                        state    <= ST_DONE;
                     end
                     default: cmd_err <= 1'b1;
                  endcase
               end
            end
            ST_LOAD: begin
               if (rx_valid) begin
                  word[{bc, 3'b000} +: 8] <= rx_data;
                  bc       <= bc + 2'd1;
                  idle_cnt <= CNT_INIT;
                  if (bc == 2'd3) begin
                     state <= ST_WRITE;
                  end
               end else if (idle_cnt == '0) begin
                  cmd_err <= 1'b1;
                  state   <= ST_IDLE;
               end else begin
                  idle_cnt <= idle_cnt - 1'b1;
               end
            end
            ST_WRITE: begin
               wp    <= wp + 1'b1;
               state <= ST_DONE;
               if (rx_valid) begin
                  cmd_err <= 1'b1;
               end
            end
`ifdef UART_CMD_ACK_EN
            ST_ACK: begin
               if (rx_valid) begin
                  cmd_err <= 1'b1;
               end
               if (tx_ready) begin
                  state <= ST_IDLE;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign imem_we    = (state == ST_WRITE);
   assign imem_addr  = wp;
   assign imem_wdata = imem_we ? word : 32'h0;
   assign cpu_en     = run_flag | step_pulse;
   assign busy       = (state != ST_IDLE);

`ifdef UART_CMD_ACK_EN
   assign tx_valid = (state == ST_ACK);
   assign tx_data  = tx_valid ? (opcode | 8'h80) : 8'h00;
`else
   logic unused_tx_ready;
   assign unused_tx_ready = tx_ready;
   assign tx_valid        = 1'b0;
   assign tx_data         = 8'h00;
`endif

endmodule
